// File: rtl/mxv_pkg.sv
// Shared definitions for the MxV sequencer slice: sequencer state encoding,
// lane/matrix size constants, index widths, the result-burst record carried
// down the result delay line, and a lane one-hot helper.
package mxv_pkg;

  localparam int unsigned LANES = 4;
  localparam int unsigned MAX_N = 8;
  localparam int unsigned IDX_W = $clog2(MAX_N);
  // One extra bit so that limits up to MAX_N (inclusive) are representable.
  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    DRAIN,
    DONE
  } state_e;

  // A group of result-FIFO pushes: rows row..row+cnt-1, one per cycle.
  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] row;
    logic [2:0]       cnt;
  } res_burst_t;

  function automatic logic [LANES-1:0] lane_onehot(input logic [1:0] lane);
    return LANES'(1) << lane;
  endfunction

endpackage

// File: rtl/mxv_sequencer_if.sv
// Handshake/control bundle between the MxV sequencer and its surroundings.
//   master : drives start, matrix_length, load_valid (matrix source / host)
//   slave  : the sequencer; drives load_ready, lane push/pop, vector select,
//            feedback select, result push/row, busy, done, error
interface mxv_sequencer_if #(
  parameter int unsigned WORD_LENGTH = 8
);
  import mxv_pkg::*;

  logic                   start;
  logic [WORD_LENGTH-1:0] matrix_length;
  logic                   load_valid;
  logic                   load_ready;
  logic [LANES-1:0]       push;
  logic                   zero_fill;
  logic [LANES-1:0]       pop;
  logic [IDX_W-1:0]       vec_idx;
  logic                   feedback_sel;
  logic                   push_result;
  logic [IDX_W-1:0]       result_row;
  logic                   busy;
  logic                   done;
  logic                   error;

  modport master (
    output start, matrix_length, load_valid,
    input  load_ready, push, zero_fill, pop, vec_idx, feedback_sel,
           push_result, result_row, busy, done, error
  );

  modport slave (
    input  start, matrix_length, load_valid,
    output load_ready, push, zero_fill, pop, vec_idx, feedback_sel,
           push_result, result_row, busy, done, error
  );

endinterface

// File: rtl/mxv_index_counter.sv
// Row/column index counter shared by the load and compute phases.
//   clr      : synchronous clear to (0,0)
//   en       : advance one element, row-major
//   row_lim  : number of rows (counter wraps to (0,0) after the last element)
//   col_lim  : number of columns (N)
//   r, c     : current row / column
//   col_last : c is the last column
//   last     : (r,c) is the last element
module mxv_index_counter
  import mxv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] row_lim,
  input  logic [CNT_W-1:0] col_lim,
  output logic [IDX_W-1:0] r,
  output logic [IDX_W-1:0] c,
  output logic             col_last,
  output logic             last
);

  logic [IDX_W-1:0] r_q, r_d;
  logic [IDX_W-1:0] c_q, c_d;

  always_comb begin
    col_last = ({1'b0, c_q} == col_lim - CNT_W'(1));
    last     = col_last && ({1'b0, r_q} == row_lim - CNT_W'(1));
    r_d      = r_q;
    c_d      = c_q;
    if (clr) begin
      r_d = '0;
      c_d = '0;
    end else if (en) begin
      if (col_last) begin
        c_d = '0;
        r_d = last ? '0 : r_q + 1'b1;
      end else begin
        c_d = c_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
      c_q <= '0;
    end else begin
      r_q <= r_d;
      c_q <= c_d;
    end
  end

  assign r = r_q;
  assign c = c_q;

endmodule

// File: rtl/mxv_sequencer.sv
// Control sequencer for the 4-lane matrix-by-vector systolic datapath.
// Loads an NxN matrix row-major into the lane FIFOs (row r -> lane r mod 4),
// zero-pads rows N..4P-1, then pops all lanes column by column for P passes,
// and pushes the result FIFO once per valid row PIPE_LAT cycles after each
// pass's final pop.
//   clk, reset : clock, synchronous active-high reset
//   bus        : mxv_sequencer_if slave (start/length/load handshake in,
//                push/pop/vec_idx/feedback_sel/result/status out)
module mxv_sequencer #(
  parameter int unsigned WORD_LENGTH = 8,
  parameter int unsigned PIPE_LAT    = 4
) (
  input  logic            clk,
  input  logic            reset,
  mxv_sequencer_if.slave  bus
);
  import mxv_pkg::*;

  localparam logic [WORD_LENGTH-1:0] MAX_N_W = WORD_LENGTH'(MAX_N);

  state_e           state_q, state_d;
  logic             pad_q, pad_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [1:0]       p_q, p_d;
  logic             error_q, error_d;
  logic [IDX_W-1:0] brow_q, brow_d;
  logic [2:0]       brem_q, brem_d;

  res_burst_t [PIPE_LAT-1:0] dl_q, dl_d;
  res_burst_t                launch;
  res_burst_t                tail;

  logic             cnt_clr, cnt_en;
  logic [CNT_W-1:0] row_lim;
  logic [IDX_W-1:0] r, c;
  logic             col_last, last;

  logic             load_ready, zero_fill, hs, real_last, dl_busy, len_ok;
  logic [CNT_W-1:0] n_plus3, base4, rows_left;

  // The same counter walks rows 0..4P-1 during LOAD and passes 0..P-1 in
  // COMPUTE (r is the pass index there).
  mxv_index_counter u_idx (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .row_lim  (row_lim),
    .col_lim  (n_q),
    .r        (r),
    .c        (c),
    .col_last (col_last),
    .last     (last)
  );

  assign load_ready = (state_q == LOAD) && !pad_q;
  assign zero_fill  = (state_q == LOAD) && pad_q;
  assign hs         = bus.load_valid && load_ready;
  assign real_last  = col_last && ({1'b0, r} == n_q - CNT_W'(1));
  assign row_lim    = (state_q == COMPUTE) ? {2'b00, p_q} : {p_q, 2'b00};
  assign tail       = dl_q[PIPE_LAT-1];
  assign len_ok     = (bus.matrix_length != '0) && (bus.matrix_length <= MAX_N_W);
  assign n_plus3    = bus.matrix_length[CNT_W-1:0] + CNT_W'(3);
  assign base4      = {1'b0, r[0], 2'b00};
  assign rows_left  = n_q - base4;

  always_comb begin
    state_d = state_q;
    pad_d   = pad_q;
    n_d     = n_q;
    p_d     = p_q;
    error_d = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    launch  = '0;

    unique case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        pad_d   = 1'b0;
        if (bus.start) begin
          if (len_ok) begin
            n_d     = bus.matrix_length[CNT_W-1:0];
            p_d     = n_plus3[3:2];
            state_d = LOAD;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (!pad_q) begin
          cnt_en = hs;
          // When N is a multiple of 4 the last real element is also the last
          // counter element, so the pad phase is skipped entirely.
          if (hs && real_last) begin
            if (n_q[1:0] == 2'b00) state_d = COMPUTE;
            else                   pad_d   = 1'b1;
          end
        end else begin
          cnt_en = 1'b1;
          if (last) begin
            pad_d   = 1'b0;
            state_d = COMPUTE;
          end
        end
      end
      COMPUTE: begin
        cnt_en = 1'b1;
        if (col_last) begin
          launch.vld = 1'b1;
          launch.row = {r[0], 2'b00};
          launch.cnt = (rows_left > CNT_W'(4)) ? 3'd4 : rows_left[2:0];
        end
        if (last) state_d = DRAIN;
      end
      DRAIN: begin
        if (!dl_busy) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result scheduling: a pass's burst record travels PIPE_LAT stages, then
  // the first row pushes straight from the tail while the remaining rows are
  // counted out of brow/brem. Bursts are >= 5 cycles apart, so they never
  // collide in the expander.
  always_comb begin
    dl_d[0] = launch;
    for (int unsigned i = 1; i < PIPE_LAT; i++) begin
      dl_d[i] = dl_q[i-1];
    end
    brow_d = brow_q;
    brem_d = brem_q;
    if (tail.vld) begin
      brow_d = tail.row + 1'b1;
      brem_d = tail.cnt - 1'b1;
    end else if (brem_q != '0) begin
      brow_d = brow_q + 1'b1;
      brem_d = brem_q - 1'b1;
    end
    dl_busy = (brem_q != '0);
    for (int unsigned i = 0; i < PIPE_LAT; i++) begin
      dl_busy = dl_busy | dl_q[i].vld;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pad_q   <= 1'b0;
      n_q     <= '0;
      p_q     <= '0;
      error_q <= 1'b0;
      brow_q  <= '0;
      brem_q  <= '0;
      dl_q    <= '0;
    end else begin
      state_q <= state_d;
      pad_q   <= pad_d;
      n_q     <= n_d;
      p_q     <= p_d;
      error_q <= error_d;
      brow_q  <= brow_d;
      brem_q  <= brem_d;
      dl_q    <= dl_d;
    end
  end

  assign bus.load_ready   = load_ready;
  assign bus.zero_fill    = zero_fill;
  assign bus.push         = (hs || zero_fill) ? lane_onehot(r[1:0]) : '0;
  assign bus.pop          = {LANES{state_q == COMPUTE}};
  assign bus.vec_idx      = (state_q == COMPUTE) ? c : '0;
  assign bus.feedback_sel = (state_q == COMPUTE) && (c != '0);
  assign bus.push_result  = tail.vld || (brem_q != '0);
  assign bus.result_row   = tail.vld ? tail.row : ((brem_q != '0) ? brow_q : '0);
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = (state_q == DONE);
  assign bus.error        = error_q;

endmodule

// File: doc/mxv_sequencer.md
# mxv_sequencer

Control sequencer for the 4-lane matrix-by-vector systolic datapath. It loads an N×N matrix row-major into the four lane FIFOs, zero-pads unused rows, and pops the lanes column by column for one or two passes. It drives the vector-element select and the accumulate/clear feedback select, and pushes the result FIFO once per valid row. It sits between the top-level MxV datapath and its matrix source, and replaces the free-running load counter.

## Interface
- WORD_LENGTH, 8, width of `matrix_length`
- LANES, 4, number of processor lanes; fixed at 4
- MAX_N, 8, largest supported matrix dimension
- PIPE_LAT, 4, cycles from a lane pop to that lane's sum at the result FIFO input
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin an operation; sampled only in IDLE
- matrix_length  in  WORD_LENGTH  N; latched on accepted start
- load_valid  in  1  matrix element present on the datapath input
- load_ready  out  1  element accepted this cycle when `load_valid` is also high
- push  out  LANES  one-hot lane FIFO push
- zero_fill  out  1  selects the constant-zero mux input for the current push
- pop  out  LANES  lane FIFO pops; all bits equal
- vec_idx  out  3  column index c; selects vector element c
- feedback_sel  out  1  1 = accumulate, 0 = clear partial sum
- push_result  out  1  result FIFO push
- result_row  out  3  row index of the current `push_result`
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at completion
- error  out  1  one-cycle pulse when `start` carries an invalid N

## Operation
- Definitions: P = ceil(N/4), the number of passes (1 or 2). Row r is assigned to lane r mod 4.
- **IDLE → LOAD**
  - Taken on `start` with 1 ≤ N ≤ MAX_N.
  - If N = 0 or N > MAX_N: pulse `error`, stay in IDLE.
- **LOAD, real phase**
  - `load_ready` = 1.
  - Each handshake (`load_valid` & `load_ready`) pushes lane (r mod 4) and advances (r,c) row-major.
  - No push occurs without a handshake.
- **LOAD, pad phase**
  - Entered after element (N-1,N-1) is accepted.
  - Covers rows N..4P-1, N elements each.
  - One push per cycle, unconditional, with `zero_fill` = 1 and `load_ready` = 0.
  - Skipped when N mod 4 = 0.
- **COMPUTE**
  - For p in 0..P-1 and c in 0..N-1: one cycle each, with `pop` = 4'b1111, `vec_idx` = c, and `feedback_sel` = (c ≠ 0).
  - Passes run back to back with no gap.
- **Result pushes**
  - After the c = N-1 pop of pass p, rows 4p..min(4p+3, N-1) are pushed.
  - One push per cycle, starting PIPE_LAT cycles after that pop, with `result_row` set to the row.
  - Pushes are generated by a delay line and may overlap the next pass's pops.
- **DRAIN**
  - Entered after the last pop.
  - Waits until the delay line is empty, then goes to DONE.
- **DONE**
  - `done` = 1 for one cycle, then returns to IDLE.
- **Boundary conditions**
  - Each lane receives exactly P·N pushes, at most 2N, so the lane FIFO of depth 2N never overflows.
  - Exactly N result pushes, so the result FIFO of depth N never overflows.
  - `start` while busy is ignored.
  - `reset` at any cycle: the next state is IDLE and every output is 0 on the following edge. The delay line and all counters are cleared.

## Timing
- Reset values: all outputs 0, state IDLE.
- All outputs are registered-state decodes; no combinational path from `start` to any output.
- `load_valid` → `push` is combinational; `push` is asserted in the same cycle as the handshake.
- Accepted `start` at edge k gives `load_ready` = 1 from cycle k+1.
- Pad phase length = (4P−N)·N cycles.
- COMPUTE length = P·N cycles.
- `done` asserts PIPE_LAT + (rows in last pass) cycles after the final pop cycle, plus one DRAIN→DONE cycle.

## Structure
- Shared package `mxv_pkg`:
  - state enum: IDLE, LOAD, COMPUTE, DRAIN, DONE
  - constants LANES and MAX_N
  - index width `IDX_W` = $clog2(MAX_N)
- Sub-module `mxv_index_counter`:
  - Row/column counter with enable and programmable limit N.
  - Outputs r, c, and a last-element flag.
  - Instantiated once, reused across LOAD and COMPUTE.

## Test plan
- **N=4, `load_valid` held high:** 16 handshakes, lanes pushed 0,0,0,0,1,1,1,1,...; no `zero_fill`; 4 pop cycles with `vec_idx` 0..3; `feedback_sel` 0,1,1,1; `push_result` for rows 0..3 starting 4 cycles after the last pop; `done` once.
- **N=5:** 25 handshakes, then 15 `zero_fill` pushes to lanes 1,2,3 (rows 5,6,7); 10 pop cycles; exactly 5 result pushes (rows 0–3 after pass 0, row 4 after pass 1).
- **N=5, `load_valid` toggling every other cycle:** pushes occur only on handshake cycles; final results are identical to the previous case.
- **`start` with N=0, then N=9:** `error` pulses each time; `busy` stays 0; no push.
- **`reset` asserted mid-COMPUTE:** next cycle all outputs 0 and state IDLE; a subsequent N=4 run completes normally.
- **`start` pulsed during LOAD:** ignored; the run ends with a single `done` and exactly N result pushes.
